piece_locker: RTL and testbench
===============================

PIECE_LOCKER -- requirements
Module: piece_locker

Interface
REQ-001 Param LINE_1, default 8'd1, grid address of row 0 / col 0.
REQ-002 Param LINE_OFFSET, default 8'd12, address stride between rows.
REQ-003 Param LINE_WIDTH, default 4'd10, playable columns per row; LINE_COUNT, default 5'd20, rows.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 lock  input  1  start request; sampled only in IDLE.
REQ-007 piece_row  input  5  row of shape cell (0,0), 0 = top.
REQ-008 piece_col  input  4  column of shape cell (0,0).
REQ-009 shape  input  16  4x4 occupancy mask; bit r*4+c = cell at row r, col c.
REQ-010 color  input  8  block value written to grid; nonzero.
REQ-011 cleared  input  1  line-clear complete, from downstream line-clear stage.
REQ-012 we  output  1  grid memory write enable.
REQ-013 addr  output  8  grid memory address.
REQ-014 data_out  output  8  grid memory write data.
REQ-015 clear_en  output  1  enable to line-clear stage.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 err  output  1  sticky: some set cell was out of range or color was zero on the last lock.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, WRITE, CLEAR, DONE.
REQ-020 IDLE: lock=1 -> LOAD; lock otherwise ignored in every state.
REQ-021 LOAD: latch piece_row, piece_col, shape, color; clear err; cell index <= 0; -> WRITE.
REQ-022 WRITE: one cycle per cell index 0..15, index increments each cycle regardless of mask; after index 15 -> CLEAR.
REQ-023 Cell address = LINE_1 + (piece_row+r)*LINE_OFFSET + (piece_col+c); row/col sums computed at 6/5 bits, product at 9 bits, no wrap.
REQ-024 Cell in range iff piece_row+r < LINE_COUNT and piece_col+c < LINE_WIDTH.
REQ-025 Set, in-range cell with color!=0: we=1, addr=cell address[7:0], data_out=latched color, for exactly that cycle.
REQ-026 Set cell out of range: no write, err<=1; color==0: no writes for whole lock, err<=1.
REQ-027 Cycles without a write: we=0, addr=0, data_out=0.
REQ-028 CLEAR: clear_en=1 held until cleared=1 is sampled; then clear_en<=0, -> DONE.
REQ-029 cleared=1 outside CLEAR SHALL be ignored.
REQ-030 DONE: done=1 for one cycle, -> IDLE; err holds until next LOAD.
REQ-031 Latency: lock sampled at edge N -> LOAD after N, index k write cycle after edge N+2+k, clear_en first high after edge N+18.
REQ-032 Empty shape (16'h0000): 16 WRITE cycles with we=0, then normal CLEAR/DONE, err unchanged (0).
REQ-033 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-034 rst=0 at a posedge: state IDLE, index 0, we=0, addr=0, data_out=0, clear_en=0, busy=0, done=0, err=0, latched fields 0.
REQ-035 Reset mid-WRITE or mid-CLEAR SHALL abort immediately; clear_en drop resets downstream stage; no further writes.

Verification
REQ-036 rst high, lock pulse, row=0, col=0, shape=16'h0033, color=8'h05 -> writes addr 1,2,13,14 data 8'h05 at index 0,1,4,5; err=0; done after cleared.
REQ-037 row=3, col=8, shape=16'h000F, color=8'h07 -> writes addr 45,46 only; err=1 after WRITE.
REQ-038 row=19, col=0, shape=16'h0011 -> write addr 229 only, row-20 cell skipped, err=1.
REQ-039 cleared held 0 for 50 cycles in CLEAR -> clear_en stays 1, done=0; cleared=1 -> clear_en 0 next edge, done pulses once, then busy=0.
REQ-040 lock pulses at every cycle while busy -> exactly one write sequence per accepted lock; rst=0 during index 6 -> we=0, clear_en=0, busy=0 next edge, no further writes.

Source files
------------

// File: rtl/piece_locker.sv
// piece_locker
// Writes the set cells of a 4x4 tetromino shape into a row-major grid
// memory, then hands off to a downstream line-clear stage and waits for
// it to finish.
//
// Parameters
//   LINE_1      grid address of row 0 / col 0
//   LINE_OFFSET address stride between rows
//   LINE_WIDTH  playable columns per row
//   LINE_COUNT  playable rows
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-low reset
//   lock       start request, honoured only while idle
//   piece_row  row of shape cell (0,0), 0 = top
//   piece_col  column of shape cell (0,0)
//   shape      4x4 occupancy mask, bit r*4+c = cell (r,c)
//   color      block value written to the grid (must be nonzero)
//   cleared    line-clear complete, from the downstream stage
//   we/addr/data_out  grid memory write port
//   clear_en   enable to the line-clear stage
//   busy       high whenever not idle
//   done       one-cycle completion pulse
//   err        sticky: an out-of-range set cell or zero color on the last lock
module piece_locker #(
    parameter logic [7:0] LINE_1      = 8'd1,
    parameter logic [7:0] LINE_OFFSET = 8'd12,
    parameter logic [3:0] LINE_WIDTH  = 4'd10,
    parameter logic [4:0] LINE_COUNT  = 5'd20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lock,
    input  logic [4:0]  piece_row,
    input  logic [3:0]  piece_col,
    input  logic [15:0] shape,
    input  logic [7:0]  color,
    input  logic        cleared,
    output logic        we,
    output logic [7:0]  addr,
    output logic [7:0]  data_out,
    output logic        clear_en,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_CLEAR = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [4:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [15:0] shape_q, shape_d;
    logic [7:0]  color_q, color_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        clear_en_q, clear_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Cell geometry for the current index, widened so nothing wraps.
    logic [5:0] row_sum;
    logic [4:0] col_sum;
    logic [8:0] row_prod;
    logic [8:0] cell_addr;
    logic       cell_in_range;

    always_comb begin
        row_sum       = {1'b0, row_q} + {4'b0, idx_q[3:2]};
        col_sum       = {1'b0, col_q} + {3'b0, idx_q[1:0]};
        row_prod      = {3'b0, row_sum} * {1'b0, LINE_OFFSET};
        cell_addr     = {1'b0, LINE_1} + row_prod + {4'b0, col_sum};
        cell_in_range = (row_sum < {1'b0, LINE_COUNT}) &&
                        (col_sum < {1'b0, LINE_WIDTH});
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        row_d      = row_q;
        col_d      = col_q;
        shape_d    = shape_q;
        color_d    = color_q;
        we_d       = 1'b0;
        addr_d     = 8'd0;
        data_d     = 8'd0;
        clear_en_d = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (lock) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                row_d   = piece_row;
                col_d   = piece_col;
                shape_d = shape;
                color_d = color;
                err_d   = 1'b0;
                idx_d   = 4'd0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (shape_q[idx_q]) begin
                    if (cell_in_range && (color_q != 8'd0)) begin
                        we_d   = 1'b1;
                        addr_d = cell_addr[7:0];
                        data_d = color_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Only a cleared seen while clear_en is already asserted
                // counts, so a stale cleared cannot skip the handshake.
                if (clear_en_q && cleared) begin
                    clear_en_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    clear_en_d = 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered from the next state so busy tracks state_q exactly.
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            row_q      <= 5'd0;
            col_q      <= 4'd0;
            shape_q    <= 16'd0;
            color_q    <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= 8'd0;
            data_q     <= 8'd0;
            clear_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            shape_q    <= shape_d;
            color_q    <= color_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            clear_en_q <= clear_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign we       = we_q;
    assign addr     = addr_q;
    assign data_out = data_q;
    assign clear_en = clear_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_piece_locker.sv
module tb_piece_locker;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;
    logic [4:0]  piece_row;
    logic [3:0]  piece_col;
    logic [15:0] shape;
    logic [7:0]  color;
    logic        cleared;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  data_out;
    logic        clear_en;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference: expected write per cell index and expected sticky error.
    int exp_we   [16];
    int exp_addr [16];
    int exp_data [16];
    int exp_err;
    int exp_nwr;

    piece_locker dut (
        .clk       (clk),
        .rst       (rst),
        .lock      (lock),
        .piece_row (piece_row),
        .piece_col (piece_col),
        .shape     (shape),
        .color     (color),
        .cleared   (cleared),
        .we        (we),
        .addr      (addr),
        .data_out  (data_out),
        .clear_en  (clear_en),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grid rules: 20 rows x 10 cols, address = 1 + row*12 + col.
    task automatic build_model(input int row, input int col, input int shp, input int colr);
        exp_err = 0;
        exp_nwr = 0;
        for (int k = 0; k < 16; k++) begin
            int rr;
            int cc;
            rr = row + k / 4;
            cc = col + k % 4;
            exp_we[k]   = 0;
            exp_addr[k] = 0;
            exp_data[k] = 0;
            if (((shp >> k) & 1) == 1) begin
                if (rr < 20 && cc < 10 && colr != 0) begin
                    exp_we[k]   = 1;
                    exp_addr[k] = 1 + rr * 12 + cc;
                    exp_data[k] = colr;
                    exp_nwr++;
                end else begin
                    exp_err = 1;
                end
            end
        end
    endtask

    // One full lock transaction. spam keeps lock high while busy;
    // noise drives junk on cleared and the piece inputs during WRITE.
    task automatic run_lock(input int row, input int col, input int shp, input int colr,
                            input int clr_delay, input bit spam, input bit noise);
        build_model(row, col, shp, colr);
        piece_row = 5'(row);
        piece_col = 4'(col);
        shape     = 16'(shp);
        color     = 8'(colr);
        lock      = 1'b1;
        tick();                             // edge N: IDLE -> LOAD
        check("busy_load", int'(busy), 1);
        lock = spam;
        tick();                             // edge N+1: latch, err cleared
        check("err_cleared_on_load", int'(err), 0);
        check("we_load", int'(we), 0);
        for (int k = 0; k < 16; k++) begin
            if (noise) begin
                piece_row = 5'($urandom);
                piece_col = 4'($urandom);
                shape     = 16'($urandom);
                color     = 8'($urandom);
                cleared   = 1'($urandom);
            end
            tick();                         // edge N+2+k
            check($sformatf("we_k%0d", k), int'(we), exp_we[k]);
            check($sformatf("addr_k%0d", k), int'(addr), exp_addr[k]);
            check($sformatf("data_k%0d", k), int'(data_out), exp_data[k]);
            check("clear_en_in_write", int'(clear_en), 0);
        end
        cleared = 1'b0;
        tick();                             // edge N+18
        check("clear_en_first", int'(clear_en), 1);
        check("err_after_write", int'(err), exp_err);
        check("we_in_clear", int'(we), 0);
        for (int d = 0; d < clr_delay; d++) begin
            tick();
            check("clear_en_hold", int'(clear_en), 1);
            check("done_hold", int'(done), 0);
            check("busy_hold", int'(busy), 1);
        end
        cleared = 1'b1;
        tick();
        check("clear_en_drop", int'(clear_en), 0);
        check("done_early", int'(done), 0);
        cleared = 1'b0;
        lock    = 1'b0;
        tick();
        check("done_pulse", int'(done), 1);
        check("busy_after_done", int'(busy), 0);
        check("err_at_done", int'(err), exp_err);
        tick();
        check("done_once", int'(done), 0);
        check("busy_idle", int'(busy), 0);
        check("err_sticky", int'(err), exp_err);
        $display("lock row=%0d col=%0d shape=%04h color=%02h writes=%0d err=%0d",
                 row, col, shp, colr, exp_nwr, exp_err);
    endtask

    initial begin
        rst       = 1'b0;
        lock      = 1'b0;
        piece_row = 5'd0;
        piece_col = 4'd0;
        shape     = 16'd0;
        color     = 8'd0;
        cleared   = 1'b0;
        tick();
        tick();
        check("rst_we", int'(we), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_clear_en", int'(clear_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b1;
        cleared = 1'b1;                     // ignored while idle
        tick();
        check("idle_cleared_ignored", int'(busy), 0);
        cleared = 1'b0;

        // Directed cases
        run_lock(0, 0, 'h0033, 'h05, 0, 1'b0, 1'b0);
        run_lock(3, 8, 'h000F, 'h07, 2, 1'b0, 1'b0);
        run_lock(19, 0, 'h0011, 'h09, 1, 1'b0, 1'b0);
        run_lock(5, 2, 'h0000, 'h03, 0, 1'b0, 1'b0);   // empty shape
        run_lock(5, 2, 'h0660, 'h00, 0, 1'b0, 1'b0);   // zero color
        run_lock(2, 4, 'h4E00, 'h11, 50, 1'b0, 1'b0);  // long clear wait
        run_lock(10, 6, 'h0272, 'h2A, 3, 1'b1, 1'b0);  // lock held while busy

        // Randomised locks against the reference model
        for (int t = 0; t < 30; t++) begin
            int row;
            int col;
            int shp;
            int colr;
            row  = (t % 5 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 19));
            col  = (t % 4 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            shp  = (t % 9 == 0) ? 0 : int'($urandom_range(0, 65535));
            colr = (t % 7 == 3) ? 0 : int'($urandom_range(1, 255));
            run_lock(row, col, shp, colr, int'($urandom_range(0, 4)), 1'($urandom), 1'b1);
        end

        // Reset during index 6 aborts immediately and stays quiet
        build_model(0, 0, 'hFFFF, 'h33);
        piece_row = 5'd0;
        piece_col = 4'd0;
        shape     = 16'hFFFF;
        color     = 8'h33;
        lock      = 1'b1;
        tick();
        lock = 1'b0;
        tick();
        for (int k = 0; k <= 6; k++) begin
            tick();
            check($sformatf("abort_we_k%0d", k), int'(we), exp_we[k]);
            check($sformatf("abort_addr_k%0d", k), int'(addr), exp_addr[k]);
        end
        rst = 1'b0;
        tick();
        check("abort_we", int'(we), 0);
        check("abort_clear_en", int'(clear_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_addr", int'(addr), 0);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("post_abort_we", int'(we), 0);
            check("post_abort_busy", int'(busy), 0);
        end
        $display("abort lock at index 6 by reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
